framebuffer_pixel_unpacker: RTL



---
 rtl/framebuffer_stream_pkg.sv | 37 +++
 rtl/framebuffer_pixel_unpacker_if.sv | 29 ++
 rtl/frame_position_counter.sv | 46 ++++
 rtl/framebuffer_pixel_unpacker.sv | 95 +++++++++
 4 files changed

// File: rtl/framebuffer_stream_pkg.sv
// Shared constants and helpers for the framebuffer word stream and its
// pixel-level consumers (unpacker, scan-out, test code).
package framebuffer_stream_pkg;

  localparam int DEFAULT_CMD_STREAM_WIDTH = 64;
  localparam int DEFAULT_PIXEL_WIDTH      = 16;
  localparam int DEFAULT_X_RESOLUTION     = 128;
  localparam int DEFAULT_Y_RESOLUTION     = 128;

  // Pixel 0 of a packed word sits in the least significant bits.
  localparam bit PIXEL0_AT_LSB = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } unpack_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int pixels_per_word(input int cmd_width, input int pixel_width);
    return cmd_width / pixel_width;
  endfunction

  function automatic int words_per_frame(input int x_res, input int y_res, input int ppw);
    return (x_res * y_res) / ppw;
  endfunction

  localparam int DEFAULT_PPW =
    pixels_per_word(DEFAULT_CMD_STREAM_WIDTH, DEFAULT_PIXEL_WIDTH);
  localparam int DEFAULT_WORDS_PER_FRAME =
    words_per_frame(DEFAULT_X_RESOLUTION, DEFAULT_Y_RESOLUTION, DEFAULT_PPW);
  localparam int DEFAULT_IDX_WIDTH = cnt_width(DEFAULT_PPW);
  localparam int DEFAULT_WC_WIDTH  = cnt_width(DEFAULT_WORDS_PER_FRAME);

endpackage

// File: rtl/framebuffer_pixel_unpacker_if.sv
// AXI-Stream style handshake bundle used for both the word input and the
// pixel output of the unpacker.
interface framebuffer_pixel_unpacker_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;
  logic [DATA_WIDTH-1:0] tdata;

  modport master (
    output tvalid,
    output tlast,
    output tuser,
    output tdata,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tlast,
    input  tuser,
    input  tdata,
    output tready
  );

endinterface

// File: rtl/frame_position_counter.sv
// Raster x/y position tracker for the output pixel stream; produces the
// end-of-line and start-of-frame markers and supports a forced frame restart.
module frame_position_counter
  import framebuffer_stream_pkg::*;
#(
  parameter int X_RESOLUTION = DEFAULT_X_RESOLUTION,
  parameter int Y_RESOLUTION = DEFAULT_Y_RESOLUTION
) (
  input  logic aclk,
  input  logic rst,
  input  logic advance,
  input  logic force_resync,
  output logic eol,
  output logic sof
);

  localparam int X_W = cnt_width(X_RESOLUTION);
  localparam int Y_W = cnt_width(Y_RESOLUTION);
  localparam logic [X_W-1:0] X_LAST = X_W'(X_RESOLUTION - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_RESOLUTION - 1);

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;

  always_ff @(posedge aclk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      // A resync restarts the raster so the next pixel is flagged as frame start.
      if (force_resync) begin
        x <= '0;
        y <= '0;
      end else if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + Y_W'(1);
      end else begin
        x <= x + X_W'(1);
      end
    end
  end

  assign eol = (x == X_LAST);
  assign sof = (x == '0) && (y == '0);

endmodule

// File: rtl/framebuffer_pixel_unpacker.sv
// Splits packed framebuffer words into a video AXI pixel stream with
// start-of-frame/end-of-line markers and checks the input frame delimiter.
module framebuffer_pixel_unpacker
  import framebuffer_stream_pkg::*;
#(
  parameter int CMD_STREAM_WIDTH = DEFAULT_CMD_STREAM_WIDTH,
  parameter int PIXEL_WIDTH      = DEFAULT_PIXEL_WIDTH,
  parameter int X_RESOLUTION     = DEFAULT_X_RESOLUTION,
  parameter int Y_RESOLUTION     = DEFAULT_Y_RESOLUTION
) (
  input  logic                         aclk,
  input  logic                         rst,
  framebuffer_pixel_unpacker_if.slave  s_fb_axis,
  framebuffer_pixel_unpacker_if.master m_pixel_axis,
  output logic                         frame_error
);

  localparam int PPW   = pixels_per_word(CMD_STREAM_WIDTH, PIXEL_WIDTH);
  localparam int WPF   = words_per_frame(X_RESOLUTION, Y_RESOLUTION, PPW);
  localparam int IDX_W = cnt_width(PPW);
  localparam int WC_W  = cnt_width(WPF);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PPW - 1);
  localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(WPF - 1);

  unpack_state_t                   state;
  logic [PPW-1:0][PIXEL_WIDTH-1:0] word;
  logic [IDX_W-1:0]                idx;
  logic [WC_W-1:0]                 wc;
  logic                            resync;

  logic full;
  logic out_fire;
  logic word_done;
  logic in_fire;
  logic early_tlast;
  logic missing_tlast;
  logic eol;
  logic sof;

  assign full          = (state == ST_FULL);
  assign out_fire      = full && m_pixel_axis.tready;
  assign word_done     = out_fire && (idx == IDX_LAST);
  // Refill is allowed in the same cycle the last pixel leaves, so there is no bubble.
  assign s_fb_axis.tready = !rst && (!full || word_done);
  assign in_fire       = s_fb_axis.tvalid && s_fb_axis.tready;
  assign early_tlast   = s_fb_axis.tlast && (wc != WC_LAST);
  assign missing_tlast = !s_fb_axis.tlast && (wc == WC_LAST);

  always_ff @(posedge aclk) begin
    if (rst) begin
      state       <= ST_EMPTY;
      // NOTE: the held word is a single register, not a memory, so it is reset
      // to keep tdata at 0 out of reset.
      word        <= '0;
      idx         <= '0;
      wc          <= '0;
      resync      <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      if (in_fire) begin
        state       <= ST_FULL;
        word        <= s_fb_axis.tdata;
        idx         <= '0;
        resync      <= early_tlast;
        frame_error <= early_tlast || missing_tlast;
        wc          <= (s_fb_axis.tlast || wc == WC_LAST) ? '0 : wc + WC_W'(1);
      end else if (out_fire) begin
        if (idx == IDX_LAST) begin
          state <= ST_EMPTY;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

  frame_position_counter #(
    .X_RESOLUTION(X_RESOLUTION),
    .Y_RESOLUTION(Y_RESOLUTION)
  ) u_position (
    .aclk        (aclk),
    .rst         (rst),
    .advance     (out_fire),
    .force_resync(word_done && resync),
    .eol         (eol),
    .sof         (sof)
  );

  assign m_pixel_axis.tvalid = full;
  assign m_pixel_axis.tdata  = PIXEL0_AT_LSB ? word[idx] : word[IDX_LAST - idx];
  assign m_pixel_axis.tlast  = full && eol;
  assign m_pixel_axis.tuser  = full && sof;

endmodule
